// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding and default width.
package seq_divider16_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// WIDTH+1-bit trial subtract for the restoring divider: a + ~b + 1 via a generate/propagate carry chain.
module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           no_borrow
);

  localparam int N = WIDTH + 1;

  logic [N-1:0] b_inv;
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  always_comb begin
    b_inv    = ~subtrahend;
    gen      = minuend & b_inv;
    prop     = minuend ^ b_inv;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  // Carry out of the top bit set means minuend >= subtrahend.
  assign diff      = prop ^ carry[N-1:0];
  assign no_borrow = carry[N];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider, one quotient bit per cycle. Define DIV_SIGNED_EN for
// two's-complement operands (abs on load, sign fix-up in FIX); default build is unsigned.
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_dividend,
  input  logic [WIDTH-1:0] data_divisor,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state, next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic             div_zero;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             exc_fix;
  logic             unused_rem_msb;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic ovf;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_val(input logic signed [WIDTH-1:0] v);
    return $unsigned(-v);
  endfunction
`endif

  // The partial remainder never exceeds the divisor, so its top bit stays zero between steps.
  assign unused_rem_msb = rem[WIDTH];
  assign rem_shift      = {rem[WIDTH-1:0], q_sh[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .minuend    (rem_shift),
    .subtrahend ({1'b0, dvs}),
    .diff       (diff),
    .no_borrow  (no_borrow)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (ctrl_div) next_state = ST_ITER;
      ST_ITER: if (count == LAST_CNT) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    quot_fix = q_sh;
    rem_fix  = rem[WIDTH-1:0];
    exc_fix  = div_zero;
`ifdef DIV_SIGNED_EN
    if (neg_q) quot_fix = neg_val(q_sh);
    if (neg_r) rem_fix  = neg_val(rem[WIDTH-1:0]);
    exc_fix = div_zero | ovf;
`endif
    if (div_zero) quot_fix = '1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      count          <= '0;
      q_sh           <= '0;
      dvs            <= '0;
      rem            <= '0;
      div_zero       <= 1'b0;
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      ovf            <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        // Load: magnitudes into the shift registers, signs and special cases recorded
        ST_IDLE: begin
          if (ctrl_div) begin
            count    <= '0;
            rem      <= '0;
            div_zero <= (data_divisor == '0);
`ifdef DIV_SIGNED_EN
            q_sh  <= abs_val(data_dividend);
            dvs   <= abs_val(data_divisor);
            neg_q <= data_dividend[WIDTH-1] ^ data_divisor[WIDTH-1];
            neg_r <= data_dividend[WIDTH-1];
            ovf   <= (data_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_divisor);
`else
            q_sh <= data_dividend;
            dvs  <= data_divisor;
`endif
          end
        end
        // Iterate: one restoring step per cycle
        ST_ITER: begin
          count <= count + 1'b1;
          if (no_borrow) begin
            rem  <= diff;
            q_sh <= {q_sh[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= rem_shift;
            q_sh <= {q_sh[WIDTH-2:0], 1'b0};
          end
        end
        // Fix-up: sign correction and output registers
        ST_FIX: begin
          data_quotient  <= quot_fix;
          data_remainder <= rem_fix;
          data_exception <= exc_fix;
        end
        default: ;
      endcase
    end
  end

  assign data_resultRDY = (state == ST_DONE);
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: vector table, scoreboard queue, and corner-case sequences.
// Expectations follow the DIV_SIGNED_EN build setting.
module tb_seq_divider16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_div = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        exception;
  logic        rdy;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   rdy_count = 0;
  exp_t sb[$];
  vec_t vecs[$];

  seq_divider16 dut (
    .clock          (clk),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_dividend  (dividend),
    .data_divisor   (divisor),
    .data_quotient  (quotient),
    .data_remainder (remainder),
    .data_exception (exception),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      exp_t x;
      rdy_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got result q=%h r=%h with nothing pending", quotient, remainder);
      end else begin
        x = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(x.q));
        chk("remainder", 32'(remainder), 32'(x.r));
        chk("exception", 32'(exception), 32'(x.e));
        chk("busy_in_rdy", 32'(busy), 32'd1);
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t m;
    if (b == 16'h0) begin
      m = '{16'hFFFF, a, 1'b1};
    end else begin
`ifdef DIV_SIGNED_EN
      logic signed [15:0] sa, sbv;
      sa  = a;
      sbv = b;
      if (a == 16'h8000 && b == 16'hFFFF) m = '{16'h8000, 16'h0000, 1'b1};
      else m = '{16'(sa / sbv), 16'(sa % sbv), 1'b0};
`else
      m = '{a / b, a % b, 1'b0};
`endif
    end
    return m;
  endfunction

  // Raise ctrl_div for exactly one rising edge; returns #1 after that (accepting) edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    ctrl_div = 1'b1;
    @(posedge clk);
    #1 ctrl_div = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; returns #1 after the edge that raises resultRDY.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        lat = n;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rdy_timeout: got no resultRDY, expected one within 40 cycles");
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input exp_t x, input bit chk_lat);
    int lat;
    sb.push_back(x);
    start_op(a, b);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_rdy(lat);
    if (chk_lat) chk("latency", 32'(lat), 32'd18);
    @(posedge clk);
    #1;
    chk("rdy_one_cycle", 32'(rdy), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_quotient", 32'(quotient), 32'(x.q));
  endtask

  initial begin
    int lat;
    int rc;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{16'd100,   16'd7,     16'd14,    16'd2,     1'b0});
    vecs.push_back('{16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0});
    vecs.push_back('{16'd100,   16'hFFF9,  16'hFFF2,  16'h0002,  1'b0});
    vecs.push_back('{16'hFF9C,  16'hFFF9,  16'h000E,  16'hFFFE,  1'b0});
    vecs.push_back('{16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b1});
    vecs.push_back('{16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1});
    vecs.push_back('{16'hFFFB,  16'h0000,  16'hFFFF,  16'hFFFB,  1'b1});
    vecs.push_back('{16'h8000,  16'h0001,  16'h8000,  16'h0000,  1'b0});
    vecs.push_back('{16'd7,     16'hFF9C,  16'h0000,  16'h0007,  1'b0});
    vecs.push_back('{16'h7FFF,  16'd2,     16'h3FFF,  16'h0001,  1'b0});
`else
    vecs.push_back('{16'd100,   16'd7,     16'd14,    16'd2,     1'b0});
    vecs.push_back('{16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1});
    vecs.push_back('{16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0});
    vecs.push_back('{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0});
    vecs.push_back('{16'h0000,  16'd5,     16'h0000,  16'h0000,  1'b0});
    vecs.push_back('{16'd7,     16'd100,   16'h0000,  16'd7,     1'b0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0});
    vecs.push_back('{16'hABCD,  16'h0013,  16'h090A,  16'h000F,  1'b0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_exception", 32'(exception), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      exp_t x;
      x = '{vecs[i].q, vecs[i].r, vecs[i].e};
      run(vecs[i].a, vecs[i].b, x, 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = (i % 2 == 1) ? 16'($urandom_range(1, 40)) : 16'($urandom);
      run(a, b, model(a, b), 1'b0);
    end

    // Start while busy is ignored
    rc = rdy_count;
    sb.push_back('{16'd10, 16'd0, 1'b0});
    start_op(16'd50, 16'd5);
    repeat (4) @(posedge clk);
    start_op(16'd9, 16'd3);
    wait_rdy(lat);
    repeat (25) @(posedge clk);
    #1;
    chk("ignored_start_pulses", 32'(rdy_count - rc), 32'd1);

    // Reset mid-operation aborts with no result pulse
    rc = rdy_count;
    start_op(16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_rdy", 32'(rdy_count - rc), 32'd0);
    run(16'd9, 16'd4, '{16'd2, 16'd1, 1'b0}, 1'b1);

    // ctrl_div held through the DONE cycle is taken one cycle later, from IDLE
    sb.push_back('{16'd14, 16'd2, 1'b0});
    start_op(16'd100, 16'd7);
    wait_rdy(lat);
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd4;
    ctrl_div = 1'b1;
    sb.push_back('{16'd2, 16'd1, 1'b0});
    @(posedge clk);
    #1;
    chk("done_start_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_start_taken", 32'(busy), 32'd1);
    ctrl_div = 1'b0;
    wait_rdy(lat);
    chk("held_start_latency", 32'(lat), 32'd18);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
